// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: elastic pipelined modular adder/subtractor.
//
// Computes (a + b) mod Q or (a - b) mod Q on WIDTH-bit operands over a
// STAGES-deep valid/ready pipeline. Operands that are not reduced (>= Q)
// produce result 0 with the error flag set. A sideband tag travels with
// every operation.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_a, in_b        operands (WIDTH bits)
//   in_op             0 = add, 1 = subtract
//   in_tag            sideband tag (TAG_W bits)
//   out_valid/ready   output handshake
//   out_result        modular result (WIDTH bits)
//   out_tag           tag of the operation on out_result
//   out_err           operand out of range for this operation
module mod_addsub_pipe #(
  parameter int WIDTH  = 12,
  parameter int Q      = 3329,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [WIDTH:0] Q_EXT = Q[WIDTH:0];

  // Per-stage state. val holds the raw sum/difference in stage 0 (when
  // STAGES >= 2) and the corrected result from stage 1 onward; flag marks
  // a value that still needs the +/-Q correction.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH:0]    val_q [STAGES];
  logic [WIDTH:0]    val_d [STAGES];
  logic [STAGES-1:0] flag_q, flag_d;
  logic [STAGES-1:0] op_q, op_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];

  logic [STAGES-1:0] stage_en;
  logic              all_full;
  logic              accept;

  logic [WIDTH:0]    a_ext, b_ext, sum_raw, diff_raw, in_raw;
  logic              in_need, in_err;

  // A flagged add overshoots by exactly Q; a flagged subtract wrapped
  // below zero, and adding Q modulo 2**(WIDTH+1) lands on a - b + Q.
  function automatic logic [WIDTH:0] correct(input logic [WIDTH:0] raw,
                                             input logic need,
                                             input logic op);
    if (!need) begin
      return raw;
    end
    if (op) begin
      return raw + Q_EXT;
    end
    return raw - Q_EXT;
  endfunction

  always_comb begin
    a_ext    = {1'b0, in_a};
    b_ext    = {1'b0, in_b};
    sum_raw  = a_ext + b_ext;
    diff_raw = a_ext - b_ext;
    in_err   = (a_ext >= Q_EXT) || (b_ext >= Q_EXT);
    in_raw   = in_op ? diff_raw : sum_raw;
    in_need  = in_op ? (a_ext < b_ext) : (sum_raw >= Q_EXT);
  end

  // Stage k can take new data unless it and every stage after it are full
  // while the output is stalled. Computed from valid bits and out_ready
  // only, so in_valid never reaches in_ready.
  always_comb begin
    stage_en = '0;
    all_full = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      all_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        all_full = all_full & valid_q[j];
      end
      stage_en[k] = out_ready || !all_full;
    end
  end

  assign in_ready = !rst && stage_en[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    val_d   = val_q;
    flag_d  = flag_q;
    op_d    = op_q;
    err_d   = err_q;
    tag_d   = tag_q;

    if (stage_en[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        tag_d[0] = in_tag;
        err_d[0] = in_err;
        op_d[0]  = in_op;
        // Errored operations are forced to zero here so the later
        // correction stage passes them through untouched.
        if (STAGES == 1) begin
          val_d[0]  = in_err ? '0 : correct(in_raw, in_need, in_op);
          flag_d[0] = 1'b0;
        end else begin
          val_d[0]  = in_err ? '0 : in_raw;
          flag_d[0] = !in_err && in_need;
        end
      end
    end

    // Stage 1 applies the correction; later stages see flag = 0 and the
    // correction degenerates to a plain copy.
    for (int k = 1; k < STAGES; k++) begin
      if (stage_en[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          val_d[k]  = correct(val_q[k-1], flag_q[k-1], op_q[k-1]);
          flag_d[k] = 1'b0;
          op_d[k]   = op_q[k-1];
          err_d[k]  = err_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      flag_q  <= '0;
      op_q    <= '0;
      err_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        val_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      flag_q  <= flag_d;
      op_q    <= op_d;
      err_q   <= err_d;
      for (int k = 0; k < STAGES; k++) begin
        val_q[k] <= val_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_result = val_q[STAGES-1][WIDTH-1:0];
  assign out_tag    = tag_q[STAGES-1];
  assign out_err    = err_q[STAGES-1];

  // The final stage's carry bit is always zero after correction, and its
  // flag/op bits have no consumer.
  logic unused_last;
  assign unused_last = ^{val_q[STAGES-1][WIDTH], flag_q[STAGES-1], op_q[STAGES-1]};

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: drives four configurations of mod_addsub_pipe with a
// shared stimulus stream and checks each against a plain-arithmetic model.
//   index 0: WIDTH=12 Q=3329  STAGES=2
//   index 1: WIDTH=12 Q=3329  STAGES=1
//   index 2: WIDTH=12 Q=3329  STAGES=4
//   index 3: WIDTH=16 Q=65521 STAGES=2
module tb_mod_addsub_pipe;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_op;
  logic [3:0]  in_tag;
  logic [15:0] a16, b16;
  logic        out_ready;

  logic        rdy_0, rdy_1, rdy_2, rdy_3;
  logic        ov_0, ov_1, ov_2, ov_3;
  logic        err_0, err_1, err_2, err_3;
  logic [3:0]  tag_0, tag_1, tag_2, tag_3;
  logic [11:0] res_0, res_1, res_2;
  logic [15:0] res_3;

  always #5 clk = ~clk;

  mod_addsub_pipe #(.WIDTH(12), .Q(3329), .STAGES(2), .TAG_W(4)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_0),
    .in_a(a16[11:0]), .in_b(b16[11:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(ov_0), .out_ready(out_ready), .out_result(res_0),
    .out_tag(tag_0), .out_err(err_0));

  mod_addsub_pipe #(.WIDTH(12), .Q(3329), .STAGES(1), .TAG_W(4)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_1),
    .in_a(a16[11:0]), .in_b(b16[11:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(ov_1), .out_ready(out_ready), .out_result(res_1),
    .out_tag(tag_1), .out_err(err_1));

  mod_addsub_pipe #(.WIDTH(12), .Q(3329), .STAGES(4), .TAG_W(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_2),
    .in_a(a16[11:0]), .in_b(b16[11:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(ov_2), .out_ready(out_ready), .out_result(res_2),
    .out_tag(tag_2), .out_err(err_2));

  mod_addsub_pipe #(.WIDTH(16), .Q(65521), .STAGES(2), .TAG_W(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_3),
    .in_a(a16), .in_b(b16), .in_op(in_op), .in_tag(in_tag),
    .out_valid(ov_3), .out_ready(out_ready), .out_result(res_3),
    .out_tag(tag_3), .out_err(err_3));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  bit          s_rdy    [NDUT];
  bit          s_ov     [NDUT];
  logic [20:0] s_obs    [NDUT];
  logic [20:0] exp_buf  [NDUT][64];
  int          head     [NDUT];
  int          tail     [NDUT];
  bit          held     [NDUT];
  logic [20:0] held_obs [NDUT];
  int          acc      [NDUT];
  int          emit     [NDUT];

  int da   [5] = '{3000, 5, 3328, 3328, 3329};
  int db   [5] = '{500, 10, 3328, 0, 1};
  bit dop  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  int dres [5] = '{171, 3324, 0, 3328, 0};
  bit derr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int dtag [5] = '{1, 2, 3, 4, 5};
  int edge_vals [8] = '{0, 1, 3328, 3329, 4095, 65520, 65521, 65535};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Result packed as {err, tag, 16-bit result}.
  function automatic logic [20:0] ref_model(int a, int b, bit op, int tag, int q);
    int r;
    bit e;
    e = (a >= q) || (b >= q);
    if (e) r = 0;
    else if (op) r = (a - b + q) % q;
    else r = (a + b) % q;
    return {e, tag[3:0], r[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 3) == 0) return 16'(edge_vals[$urandom_range(0, 7)]);
    if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 3328));
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [15:0] b,
                               input bit op, input logic [3:0] tag);
    in_valid = v;
    a16      = a;
    b16      = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  // One clock cycle: sample at the falling edge, score handshakes that the
  // next rising edge will complete, then return just after that edge.
  task automatic checkOutput();
    @(negedge clk);
    cyc++;
    s_rdy[0] = rdy_0; s_ov[0] = ov_0; s_obs[0] = {err_0, tag_0, 4'h0, res_0};
    s_rdy[1] = rdy_1; s_ov[1] = ov_1; s_obs[1] = {err_1, tag_1, 4'h0, res_1};
    s_rdy[2] = rdy_2; s_ov[2] = ov_2; s_obs[2] = {err_2, tag_2, 4'h0, res_2};
    s_rdy[3] = rdy_3; s_ov[3] = ov_3; s_obs[3] = {err_3, tag_3, res_3};
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        head[i] = 0;
        tail[i] = 0;
        held[i] = 1'b0;
      end else begin
        if (held[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(s_ov[i]), 1);
          chk($sformatf("hold_data%0d", i), 32'(s_obs[i]), 32'(held_obs[i]));
        end
        if (s_ov[i] && out_ready) begin
          emit[i]++;
          chk($sformatf("not_stale%0d", i), 32'(head[i] != tail[i]), 1);
          if (head[i] != tail[i]) begin
            chk($sformatf("result%0d", i), 32'(s_obs[i]), 32'(exp_buf[i][head[i] % 64]));
            head[i]++;
          end
        end
        if (in_valid && s_rdy[i]) begin
          int qa, qb, q;
          qa = (i == 3) ? int'(a16) : int'(a16[11:0]);
          qb = (i == 3) ? int'(b16) : int'(b16[11:0]);
          q  = (i == 3) ? 65521 : 3329;
          acc[i]++;
          exp_buf[i][tail[i] % 64] = ref_model(qa, qb, in_op, int'(in_tag), q);
          tail[i]++;
        end
        held[i]     = s_ov[i] && !out_ready;
        held_obs[i] = s_obs[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first, last, cnt, acc0, c0;

    for (int i = 0; i < NDUT; i++) begin
      head[i] = 0; tail[i] = 0; held[i] = 1'b0; acc[i] = 0; emit[i] = 0;
      held_obs[i] = '0; s_obs[i] = '0; s_rdy[i] = 1'b0; s_ov[i] = 1'b0;
    end
    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);

    $display("[TB] reset");
    checkOutput();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(s_rdy[i]), 0);
      chk($sformatf("rst_valid%0d", i), 32'(s_ov[i]), 0);
      chk($sformatf("rst_data%0d", i), 32'(s_obs[i]), 0);
    end
    rst = 1'b0;
    checkOutput();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("post_rst_ready%0d", i), 32'(s_rdy[i]), 1);
      chk($sformatf("post_rst_valid%0d", i), 32'(s_ov[i]), 0);
    end

    $display("[TB] directed cases");
    for (int t = 0; t < 5; t++) begin
      applyStimulus(1'b1, 16'(da[t]), 16'(db[t]), dop[t], 4'(dtag[t]));
      checkOutput();
      chk("dir_accept", 32'(s_rdy[0]), 1);
      applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
      checkOutput();
      chk("dir_lat1", 32'(s_ov[0]), 0);
      checkOutput();
      chk("dir_lat2", 32'(s_ov[0]), 1);
      chk("dir_value", 32'({derr[t], 4'(dtag[t]), 16'(dres[t])}), 32'(s_obs[0]));
    end
    repeat (4) checkOutput();

    $display("[TB] back-to-back streaming");
    first = -1; last = -1; cnt = 0; acc0 = 0; c0 = cyc + 1;
    for (int s = 0; s < 22; s++) begin
      if (s < 16)
        applyStimulus(1'b1, 16'($urandom_range(0, 3328)), 16'($urandom_range(0, 3328)),
                      1'($urandom_range(0, 1)), 4'(s));
      else
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
      checkOutput();
      if (s < 16 && s_rdy[0]) acc0++;
      if (s_ov[0]) begin
        cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("stream_accepts", 32'(acc0), 16);
    chk("stream_count", 32'(cnt), 16);
    chk("stream_span", 32'(last - first), 15);
    chk("stream_latency", 32'(first - c0), 2);

    $display("[TB] backpressure");
    repeat (6) checkOutput();
    for (int i = 0; i < NDUT; i++) acc[i] = 0;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 4'(s + 8));
      checkOutput();
    end
    chk("bp_accepts0", 32'(acc[0]), 2);
    chk("bp_accepts1", 32'(acc[1]), 1);
    chk("bp_accepts2", 32'(acc[2]), 4);
    chk("bp_accepts3", 32'(acc[3]), 2);
    chk("bp_ready", 32'(s_rdy[0]), 0);
    chk("bp_valid", 32'(s_ov[0]), 1);
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
    repeat (8) checkOutput();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("bp_drained%0d", i), 32'(tail[i] - head[i]), 0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 16'd100, 16'd200, 1'b0, 4'hA);
    checkOutput();
    applyStimulus(1'b1, 16'd300, 16'd50, 1'b1, 4'hB);
    checkOutput();
    chk("rs_inflight", 32'(tail[0] - head[0]), 2);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
    rst = 1'b1;
    checkOutput();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("rs_ready_low%0d", i), 32'(s_rdy[i]), 0);
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) emit[i] = 0;
    checkOutput();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rs_valid%0d", i), 32'(s_ov[i]), 0);
      chk($sformatf("rs_ready_back%0d", i), 32'(s_rdy[i]), 1);
    end
    repeat (6) checkOutput();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("rs_no_stale%0d", i), 32'(emit[i]), 0);

    $display("[TB] random regression");
    for (int n = 0; n < 800; n++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      applyStimulus(($urandom_range(0, 9) < 7), pick(), pick(),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      checkOutput();
    end
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 4'd0);
    repeat (12) checkOutput();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("rand_drained%0d", i), 32'(tail[i] - head[i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 12, operand/result width in bits.
REQ-002 SHALL have parameter Q, default 3329, modulus; legal range 2 <= Q < 2**WIDTH.
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth in cycles; legal range 1..4.
REQ-004 SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have in_valid  input  1  input operation present.
REQ-008 SHALL have in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have in_a  input  WIDTH  operand a.
REQ-010 SHALL have in_b  input  WIDTH  operand b.
REQ-011 SHALL have in_op  input  1  0 = (a+b) mod Q, 1 = (a-b) mod Q.
REQ-012 SHALL have in_tag  input  TAG_W  sideband, carried unchanged to output.
REQ-013 SHALL have out_valid  output  1  result present.
REQ-014 SHALL have out_ready  input  1  downstream accepts result.
REQ-015 SHALL have out_result  output  WIDTH  modular result.
REQ-016 SHALL have out_tag  output  TAG_W  tag of the operation in out_result.
REQ-017 SHALL have out_err  output  1  operand out of range (a >= Q or b >= Q).

Function
REQ-018 SHALL transfer input on a cycle where in_valid && in_ready; output on a cycle where out_valid && out_ready.
REQ-019 SHALL implement an elastic pipeline of STAGES registers, each with its own valid bit; stage k advances when stage k+1 is empty or advancing; last stage advances when out_ready is high.
REQ-020 SHALL drive in_ready = !rst && (stage-0 empty || stage 0 advancing); no combinational path from in_valid to in_ready.
REQ-021 SHALL produce out_valid exactly STAGES cycles after acceptance when out_ready is held high; sustained throughput one operation per cycle.
REQ-022 SHALL hold out_result, out_tag, out_err stable while out_valid && !out_ready.
REQ-023 SHALL never drop, duplicate or reorder accepted operations under any in_valid/out_ready pattern.
REQ-024 SHALL compute the add path as s = a + b in WIDTH+1 bits; result = s - Q if s >= Q, else s.
REQ-025 SHALL compute the subtract path as a - b if a >= b, else a - b + Q, evaluated in WIDTH+1 bits without truncation before the final correction.
REQ-026 SHALL, for STAGES >= 2, register the raw sum/difference and its compare flag in stage 0 and apply the Q correction in stage 1; remaining stages are pure delay; for STAGES = 1, do all of it in one stage.
REQ-027 SHALL, when a >= Q or b >= Q, output out_result = 0 and out_err = 1 for that operation; otherwise out_err = 0.
REQ-028 SHALL guarantee out_result < Q whenever out_err = 0.
REQ-029 SHALL handle simultaneous accept and emit on one cycle with a full pipeline without a bubble.

Reset
REQ-030 SHALL, while rst is high at a clock edge, clear all stage valid bits and set out_valid = 0, out_result = 0, out_tag = 0, out_err = 0.
REQ-031 SHALL hold in_ready = 0 while rst is high; in_ready = 1 on the first cycle after rst is released.
REQ-032 SHALL discard in-flight operations when rst is asserted mid-operation; none appear at the output after reset.

Verification
REQ-033 SHALL pass directed cases with STAGES=2, Q=3329, out_ready=1: add 3000+500 -> 171; sub 5-10 -> 3324; sub 3328-3328 -> 0; add 3328+0 -> 3328; each output exactly 2 cycles after accept.
REQ-034 SHALL pass out-of-range operands: add a=3329, b=1, tag=0x5 -> out_result=0, out_err=1, out_tag=0x5.
REQ-035 SHALL pass back-to-back streaming: 16 consecutive ops with distinct tags, out_ready=1 -> 16 results on 16 consecutive cycles, in order, matching the reference model.
REQ-036 SHALL pass backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after STAGES accepts, output held stable; on release all ops emerge in order, none lost.
REQ-037 SHALL pass reset mid-stream: rst asserted with 2 ops in flight -> next-cycle out_valid=0, in_ready=0; after release, no stale results appear.
REQ-038 SHALL pass random regression for STAGES in {1,2,4}, WIDTH=12 and WIDTH=16 with Q=65521, random valid/ready, against the reference model.
